// File: rtl/dac_cmd_seq_if.sv
// SPI frame handshake between the DAC command sequencer and its spi_master.
// master: sequencer side (arms frames), slave: spi_master side (reports completion).
interface dac_cmd_seq_if #(
    parameter int unsigned WID = 24
);
    logic           spi_arm;
    logic           spi_finished;
    logic [WID-1:0] spi_to_slave;
    logic [WID-1:0] spi_from_slave;

    modport master (
        output spi_arm,
        output spi_to_slave,
        input  spi_finished,
        input  spi_from_slave
    );

    modport slave (
        input  spi_arm,
        input  spi_to_slave,
        output spi_finished,
        output spi_from_slave
    );
endinterface

// File: rtl/dac_cmd_seq.sv
// Command sequencer for a 24-bit-frame SPI DAC: initialises and verifies the control
// register, then serves setpoint writes (priority) and setpoint readbacks.
module dac_cmd_seq #(
    parameter int unsigned          WID       = 24,
    parameter int unsigned          DATA_WID  = 20,
    parameter logic [DATA_WID-1:0]  CTRL_INIT = DATA_WID'(20'h00012),
    parameter int unsigned          GAP_CYC   = 2
) (
    input  logic                clk,
    input  logic                rst_L,
    dac_cmd_seq_if.master       spi,
    input  logic                wr_req,
    input  logic [DATA_WID-1:0] wr_data,
    output logic                wr_ack,
    input  logic                rd_req,
    output logic                rd_valid,
    output logic [DATA_WID-1:0] rd_data,
    output logic                init_done,
    output logic                init_err
);

    localparam int unsigned CMD_W = 4;
    localparam int unsigned CNT_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

    localparam logic [CMD_W-1:0] CMD_NOP     = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_WR_DAC  = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_WR_CTRL = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_RD_DAC  = 4'b1001;
    localparam logic [CMD_W-1:0] CMD_RD_CTRL = 4'b1010;

    typedef enum logic [2:0] {
        S_INIT_WR,
        S_INIT_RD,
        S_INIT_NOP,
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_NOP,
        S_HALT
    } state_e;

    // Per-frame handshake phase; PH_START is also the resting phase outside frame states.
    typedef enum logic [1:0] {
        PH_START,
        PH_BUSY,
        PH_DROP,
        PH_GAP
    } phase_e;

    state_e              state_q,     state_d;
    phase_e              phase_q,     phase_d;
    logic [CNT_W-1:0]    gap_cnt_q,   gap_cnt_d;
    logic                arm_q,       arm_d;
    logic [WID-1:0]      tx_q,        tx_d;
    logic [WID-1:0]      rx_q,        rx_d;
    logic [DATA_WID-1:0] wdata_q,     wdata_d;
    logic                retry_q,     retry_d;
    logic                wr_ack_q,    wr_ack_d;
    logic                rd_valid_q,  rd_valid_d;
    logic [DATA_WID-1:0] rd_data_q,   rd_data_d;
    logic                init_done_q, init_done_d;
    logic                init_err_q,  init_err_d;

    logic                frame_state;
    logic                frame_done;
    logic [WID-1:0]      frame_word;
    logic [CMD_W-1:0]    rx_hdr;
    logic [DATA_WID-1:0] rx_payload;

    assign rx_hdr     = rx_q[WID-1 -: CMD_W];
    assign rx_payload = rx_q[DATA_WID-1:0];

    // Frame to launch for the current sequencer state.
    always_comb begin
        frame_state = 1'b1;
        frame_word  = {CMD_NOP, DATA_WID'(0)};
        case (state_q)
            S_INIT_WR:  frame_word = {CMD_WR_CTRL, CTRL_INIT};
            S_INIT_RD:  frame_word = {CMD_RD_CTRL, DATA_WID'(0)};
            S_INIT_NOP: frame_word = {CMD_NOP,     DATA_WID'(0)};
            S_WR:       frame_word = {CMD_WR_DAC,  wdata_q};
            S_RD:       frame_word = {CMD_RD_DAC,  DATA_WID'(0)};
            S_RD_NOP:   frame_word = {CMD_NOP,     DATA_WID'(0)};
            default:    frame_state = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        gap_cnt_d   = gap_cnt_q;
        arm_d       = arm_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        wdata_d     = wdata_q;
        retry_d     = retry_q;
        wr_ack_d    = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        frame_done  = 1'b0;

        // Frame handshake: arm, wait finished, drop arm, wait finished low, then idle gap.
        case (phase_q)
            PH_START: begin
                if (frame_state) begin
                    arm_d   = 1'b1;
                    tx_d    = frame_word;
                    phase_d = PH_BUSY;
                end
            end
            PH_BUSY: begin
                if (spi.spi_finished) begin
                    rx_d    = spi.spi_from_slave;
                    arm_d   = 1'b0;
                    phase_d = PH_DROP;
                end
            end
            PH_DROP: begin
                if (!spi.spi_finished) begin
                    if (GAP_CYC == 0) begin
                        frame_done = 1'b1;
                    end else begin
                        phase_d   = PH_GAP;
                        gap_cnt_d = CNT_W'(0);
                    end
                end
            end
            PH_GAP: begin
                gap_cnt_d = gap_cnt_q + CNT_W'(1);
                if ((32'(gap_cnt_q) + 32'd1) >= GAP_CYC) begin
                    frame_done = 1'b1;
                end
            end
            default: phase_d = PH_START;
        endcase

        if (frame_done) begin
            phase_d = PH_START;
        end

        case (state_q)
            S_INIT_WR: if (frame_done) state_d = S_INIT_RD;
            S_INIT_RD: if (frame_done) state_d = S_INIT_NOP;
            S_INIT_NOP: begin
                if (frame_done) begin
                    if (rx_hdr == CMD_RD_CTRL && rx_payload == CTRL_INIT) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        init_err_d = 1'b1;
                        state_d    = S_HALT;
                    end
                end
            end
            S_IDLE: begin
                if (wr_req) begin
                    wr_ack_d = 1'b1;
                    wdata_d  = wr_data;
                    state_d  = S_WR;
                end else if (rd_req) begin
                    retry_d = 1'b0;
                    state_d = S_RD;
                end
            end
            S_WR: if (frame_done) state_d = S_IDLE;
            S_RD: if (frame_done) state_d = S_RD_NOP;
            S_RD_NOP: begin
                if (frame_done) begin
                    if (rx_hdr == CMD_RD_DAC) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = rx_payload;
                        state_d    = S_IDLE;
                    end else if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = S_RD;
                    end else begin
                        init_err_d  = 1'b1;
                        init_done_d = 1'b0;
                        state_d     = S_HALT;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= S_INIT_WR;
            phase_q     <= PH_START;
            gap_cnt_q   <= '0;
            arm_q       <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            wdata_q     <= '0;
            retry_q     <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            gap_cnt_q   <= gap_cnt_d;
            arm_q       <= arm_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            wdata_q     <= wdata_d;
            retry_q     <= retry_d;
            wr_ack_q    <= wr_ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
        end
    end

    assign spi.spi_arm      = arm_q;
    assign spi.spi_to_slave = tx_q;
    assign wr_ack           = wr_ack_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign init_done        = init_done_q;
    assign init_err         = init_err_q;

endmodule
